// File: rtl/dly_tap_ctrl_pkg.sv
// Shared types and helpers for the IDELAYE3 tap sequencer.
package dly_tap_ctrl_pkg;

  typedef enum logic [2:0] {INIT, IDLE, STEP, SETTLE, DONE} dly_state_t;

  localparam int DLY_DEFAULT_TAPS = 6;

  function automatic int tap_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dly_settle_timer.sv
// Loadable down-counter; zero flag marks the end of an init or settle interval.
module dly_settle_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  cnt <= '0;
    else if (load)            cnt <= value;
    else if (dec && cnt != 0) cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dly_tap_ctrl.sv
// Steps one IDELAYE3 delay line to a requested tap, one CE pulse per settle interval.
// Optional DLY_TAP_CTRL_RANGE_ERR_EN: reject out-of-range targets with a req_err pulse.
module dly_tap_ctrl
  import dly_tap_ctrl_pkg::*;
#(
  parameter int NUM_TAPS      = DLY_DEFAULT_TAPS,
  parameter int TAP_W         = tap_width(NUM_TAPS),
  parameter int SETTLE_CYCLES = 4,
  parameter int RST_CYCLES    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             recal,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAP_W-1:0] req_tap,
  output logic             busy,
  output logic             done,
`ifdef DLY_TAP_CTRL_RANGE_ERR_EN
  output logic             req_err,
`endif
  output logic [TAP_W-1:0] cur_tap,
  output logic             dly_rst,
  output logic             dly_ce,
  output logic             dly_inc
);

  localparam int               CNT_W   = 8;
  localparam logic [TAP_W-1:0] MAX_TAP = TAP_W'(NUM_TAPS);

  dly_state_t       state, nstate;
  logic             init_arm, arm_n;
  logic [TAP_W-1:0] tgt, tgt_n;
  logic             inc_n;
  logic             tmr_ld, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             req_oor;
  logic [TAP_W-1:0] req_clamp;
`ifdef DLY_TAP_CTRL_RANGE_ERR_EN
  logic             err_q, err_n;
`endif

  assign req_oor   = (req_tap > MAX_TAP);
  assign req_clamp = req_oor ? MAX_TAP : req_tap;

  dly_settle_timer #(.W(CNT_W)) u_tmr (
    .CLK   (CLK),
    .RST   (RST),
    .load  (tmr_ld),
    .dec   (tmr_dec),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  always_comb begin
    nstate  = state;
    arm_n   = init_arm;
    tgt_n   = tgt;
    inc_n   = 1'b0;
    tmr_ld  = 1'b0;
    tmr_dec = 1'b0;
    tmr_val = '0;
`ifdef DLY_TAP_CTRL_RANGE_ERR_EN
    err_n   = err_q;
`endif
    case (state)
      // The first INIT cycle arms the timer; that cycle counts toward RST_CYCLES.
      INIT: begin
        if (!init_arm) begin
          if (RST_CYCLES == 1) begin
            nstate = IDLE;
          end else begin
            tmr_ld  = 1'b1;
            tmr_val = CNT_W'(RST_CYCLES - 2);
            arm_n   = 1'b1;
          end
        end else if (tmr_zero) begin
          nstate = IDLE;
          arm_n  = 1'b0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      IDLE: begin
        if (req_valid && req_ready) begin
          tgt_n = req_clamp;
`ifdef DLY_TAP_CTRL_RANGE_ERR_EN
          err_n = req_oor;
          if (req_oor)                    nstate = DONE;
          else if (req_clamp == cur_tap)  nstate = DONE;
`else
          if (req_clamp == cur_tap)       nstate = DONE;
`endif
          else begin
            nstate = STEP;
            inc_n  = (req_clamp > cur_tap);
          end
        end
      end
      STEP: begin
        nstate  = SETTLE;
        tmr_ld  = 1'b1;
        tmr_val = CNT_W'(SETTLE_CYCLES - 1);
      end
      SETTLE: begin
        if (!tmr_zero)            tmr_dec = 1'b1;
        else if (cur_tap != tgt) begin
          nstate = STEP;
          inc_n  = (tgt > cur_tap);
        end else                  nstate = DONE;
      end
      DONE:    nstate = IDLE;
      default: nstate = INIT;
    endcase
    // recal wins over everything, including a same-cycle accept.
    if (recal) begin
      nstate = INIT;
      arm_n  = 1'b0;
      tmr_ld = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= INIT;
      init_arm  <= 1'b0;
      tgt       <= '0;
      dly_rst   <= 1'b1;
      dly_ce    <= 1'b0;
      dly_inc   <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
`ifdef DLY_TAP_CTRL_RANGE_ERR_EN
      err_q     <= 1'b0;
      req_err   <= 1'b0;
`endif
    end else begin
      state     <= nstate;
      init_arm  <= arm_n;
      tgt       <= tgt_n;
      dly_rst   <= (nstate == INIT);
      dly_ce    <= (nstate == STEP);
      dly_inc   <= (nstate == STEP) && inc_n;
      req_ready <= (nstate == IDLE);
      busy      <= (nstate != IDLE);
`ifdef DLY_TAP_CTRL_RANGE_ERR_EN
      err_q     <= err_n;
      done      <= (nstate == DONE) && !err_n;
      req_err   <= (nstate == DONE) && err_n;
`else
      done      <= (nstate == DONE);
`endif
    end
  end

  // Shadow moves on the same edge the delay line samples CE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  cur_tap <= '0;
    else if (nstate == INIT)  cur_tap <= '0;
    else if (state == STEP) begin
      if (dly_inc && cur_tap != MAX_TAP)   cur_tap <= cur_tap + TAP_W'(1);
      else if (!dly_inc && cur_tap != '0)  cur_tap <= cur_tap - TAP_W'(1);
    end
  end

endmodule

// File: tb/tb_dly_tap_ctrl.sv
// Self-checking bench for dly_tap_ctrl: vector table, random targets vs a
// transaction-level model, recal and mid-operation reset sequences.
module tb_dly_tap_ctrl;

  localparam int S  = 4;
  localparam int NT = 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       recal = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_tap = '0;
  logic       req_ready, busy, done, dly_rst, dly_ce, dly_inc;
  logic [2:0] cur_tap;
`ifdef DLY_TAP_CTRL_RANGE_ERR_EN
  logic       req_err;
`endif

  dly_tap_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .recal     (recal),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tap   (req_tap),
    .busy      (busy),
    .done      (done),
`ifdef DLY_TAP_CTRL_RANGE_ERR_EN
    .req_err   (req_err),
`endif
    .cur_tap   (cur_tap),
    .dly_rst   (dly_rst),
    .dly_ce    (dly_ce),
    .dly_inc   (dly_inc)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int mtap   = 0;

  // Behavioural delay line: thermometer select shifted by CE/INC, cleared by RST.
  logic [5:0] sel_m;
  always @(posedge CLK or posedge RST) begin
    if (RST)         sel_m <= '0;
    else if (dly_rst) sel_m <= '0;
    else if (dly_ce)  sel_m <= dly_inc ? {sel_m[4:0], 1'b1} : {1'b0, sel_m[5:1]};
  end

  logic prev_ce = 1'b0;
  always @(negedge CLK) begin
    if (RST) prev_ce <= 1'b0;
    else begin
      checks++;
      if ((dly_ce && prev_ce) || (dly_ce && dly_rst)) begin
        errors++;
        $display("FAIL ce_rule ce=%0b prev_ce=%0b dly_rst=%0b t=%0t", dly_ce, prev_ce, dly_rst, $time);
      end
      if (!dly_rst) begin
        checks++;
        if (int'(cur_tap) != $countones(sel_m)) begin
          errors++;
          $display("FAIL shadow cur_tap=%0d line_taps=%0d t=%0t", cur_tap, $countones(sel_m), $time);
        end
      end
      prev_ce <= dly_ce;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int therm(input int t);
    int r = 0;
    for (int i = 0; i < t; i++) r = r | (1 << i);
    return r;
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic wait_ready(input string nm);
    int w = 0;
    while (!req_ready && w < 60) begin tick(); w++; end
    chk(nm, req_ready, 1);
  endtask

  // Issue one request and check the full CE/done pattern against the expectation.
  task automatic do_req(input string nm, input int t, input int e_tap,
                        input int e_lat, input int e_err, input int e_sel);
    int k, up, bad, first_bad, dn;
    bit exp_ce, exp_dn;
    wait_ready({nm, "_ready"});
    req_valid = 1'b1;
    req_tap   = 3'(t);
    tick();
    req_valid = 1'b0;
    k  = e_err ? 0 : absd(e_tap, mtap);
    up = (e_tap > mtap);
    bad = 0; first_bad = 0; dn = -1;
    for (int n = 1; n <= e_lat + 6; n++) begin
      exp_ce = (k > 0) && (n < e_lat) && ((n - 1) % (S + 1) == 0);
      exp_dn = !e_err && (n == e_lat);
      if (dly_ce != exp_ce || (exp_ce && int'(dly_inc) != up) || done != exp_dn) begin
        if (bad == 0) first_bad = n;
        bad++;
      end
`ifdef DLY_TAP_CTRL_RANGE_ERR_EN
      if (req_err != (e_err != 0 && n == 1)) begin
        if (bad == 0) first_bad = n;
        bad++;
      end
`endif
      if (done && dn < 0) dn = n;
      tick();
    end
    if (bad != 0) $display("FAIL %s_pattern first bad cycle %0d after accept", nm, first_bad);
    chk({nm, "_pattern_bad"}, bad, 0);
    if (!e_err) chk({nm, "_done_lat"}, dn, e_lat);
    chk({nm, "_cur_tap"}, int'(cur_tap), e_tap);
    chk({nm, "_sel"}, int'(sel_m), e_sel);
    mtap = e_tap;
  endtask

  typedef struct {
    int tap;
    int e_tap;
    int e_lat;
    int e_err;
    int e_sel;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cnt, n, t, te, lat, err, dn;

    tbl[0] = '{3, 3, 16, 0, 'h07};
    tbl[1] = '{5, 5, 11, 0, 'h1F};
    tbl[2] = '{2, 2, 16, 0, 'h03};
    tbl[3] = '{4, 4, 11, 0, 'h0F};
    tbl[4] = '{4, 4,  1, 0, 'h0F};
`ifdef DLY_TAP_CTRL_RANGE_ERR_EN
    tbl[5] = '{7, 4,  1, 1, 'h0F};
    tbl[6] = '{0, 0, 21, 0, 'h00};
`else
    tbl[5] = '{7, 6, 11, 0, 'h3F};
    tbl[6] = '{0, 0, 31, 0, 'h00};
`endif

    // Reset state and init length
    tick(); tick();
    chk("rst_dly_rst",   dly_rst,   1);
    chk("rst_busy",      busy,      1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cur_tap",   int'(cur_tap), 0);
    chk("rst_dly_ce",    dly_ce,    0);
    chk("rst_done",      done,      0);
    RST = 1'b0;
    cnt = 0; n = 0;
    while (!req_ready && n < 10) begin
      if (dly_rst) cnt++;
      tick(); n++;
    end
    chk("init_rst_len",     cnt,   2);
    chk("init_ready_cycle", n + 1, 3);
    chk("init_cur_tap",     int'(cur_tap), 0);
    mtap = 0;

    for (int i = 0; i < 7; i++)
      do_req($sformatf("vec%0d", i), tbl[i].tap, tbl[i].e_tap, tbl[i].e_lat, tbl[i].e_err, tbl[i].e_sel);

    // Random targets against the transaction model
    for (int i = 0; i < 40; i++) begin
      t = int'($urandom_range(0, 7));
      err = 0;
`ifdef DLY_TAP_CTRL_RANGE_ERR_EN
      if (t > NT) begin err = 1; te = mtap; lat = 1; end
      else begin te = t; lat = 1 + absd(te, mtap) * (S + 1); end
`else
      te  = (t > NT) ? NT : t;
      lat = 1 + absd(te, mtap) * (S + 1);
`endif
      do_req($sformatf("rnd%0d", i), t, te, lat, err, therm(te));
      repeat ($urandom_range(0, 2)) tick();
    end

    // recal during SETTLE of a 0->6 move
    do_req("to_zero", 0, 0, 1 + mtap * (S + 1), 0, 'h00);
    wait_ready("recal_ready");
    req_valid = 1'b1; req_tap = 3'd6;
    tick();
    req_valid = 1'b0;
    repeat (7) tick();
    recal = 1'b1;
    tick();
    recal = 1'b0;
    cnt = 0; dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (dly_rst) cnt++;
      if (done) dn++;
      tick();
    end
    chk("recal_rst_len", cnt, 2);
    chk("recal_no_done", dn, 0);
    chk("recal_cur_tap", int'(cur_tap), 0);
    chk("recal_sel",     int'(sel_m), 0);
    chk("recal_ready",   req_ready, 1);
    mtap = 0;
    do_req("post_recal", 2, 2, 11, 0, 'h03);

    // RST in the middle of a move
    req_valid = 1'b1; req_tap = 3'd5;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    RST = 1'b1;
    #1;
    chk("midrst_cur_tap", int'(cur_tap), 0);
    chk("midrst_dly_rst", dly_rst, 1);
    chk("midrst_busy",    busy,    1);
    chk("midrst_dly_ce",  dly_ce,  0);
    chk("midrst_sel",     int'(sel_m), 0);
    tick();
    RST = 1'b0;
    mtap = 0;
    do_req("post_rst", 1, 1, 6, 0, 'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
